// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, default baud divisor and frame constants.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam int UART_DEF_CLKS_PER_BIT = 868;
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_START  = ST_START,
    S_DATA   = ST_DATA,
    S_PARITY = ST_PARITY,
    S_STOP   = ST_STOP
  } uart_state_e;

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, wraps, and is held at 0 by clear.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 868,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             bit_end
);

  logic [CNT_W-1:0] count_q, count_d;

  assign bit_end = (count_q == CNT_W'(CLKS_PER_BIT - 1));
  assign count   = count_q;

  always_comb begin
    count_d = count_q + 1'b1;
    if (clear || bit_end) count_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-byte holding register fed by a FIFO strobe.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
import uart_pkg::*;

module uart_tx #(
  parameter int CLKS_PER_BIT = UART_DEF_CLKS_PER_BIT,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       tx,
  output logic       busy,
  output logic       tx_done,
  output logic       overrun
);

  uart_state_e      state_q, state_d;
  logic [7:0]       shift_q, shift_d, hold_q, hold_d, load_byte;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic             hold_full_q, hold_full_d, overrun_q, overrun_d;
  logic             tx_q, tx_d, busy_q, busy_d, tx_done_q, tx_done_d;
  logic             load_en, stop_end, bit_end;
  logic [CNT_W-1:0] count;
`ifdef UART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT), .CNT_W(CNT_W)) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_q == S_IDLE),
    .count   (count),
    .bit_end (bit_end)
  );

  assign stop_end = (state_q == S_STOP) && bit_end;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    overrun_d   = overrun_q;
    bit_idx_d   = bit_idx_q;
    load_en     = 1'b0;
    load_byte   = data_in;
`ifdef UART_TX_PARITY_EN
    parity_d    = parity_q;
`endif
    case (state_q)
      S_IDLE: if (data_valid) begin
        load_en = 1'b1;
        state_d = S_START;
      end
      S_START: if (bit_end) begin
        state_d   = S_DATA;
        bit_idx_d = '0;
      end
      S_DATA: if (bit_end) begin
        shift_d = {1'b0, shift_q[7:1]};
        if (bit_idx_q == 3'(DATA_BITS - 1)) begin
          bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
          state_d   = S_PARITY;
`else
          state_d   = S_STOP;
`endif
        end else begin
          bit_idx_d = bit_idx_q + 3'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (bit_end) state_d = S_STOP;
`endif
      S_STOP: if (bit_end) begin
        // A held byte takes priority; a same-cycle strobe then refills the hold.
        if (hold_full_q) begin
          load_en     = 1'b1;
          load_byte   = hold_q;
          hold_full_d = 1'b0;
          state_d     = S_START;
        end else if (data_valid) begin
          load_en = 1'b1;
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load_en) begin
      shift_d = load_byte;
`ifdef UART_TX_PARITY_EN
      parity_d = even_parity(load_byte);
`endif
    end

    if (data_valid && (state_q != S_IDLE)) begin
      if (stop_end) begin
        if (hold_full_q) begin
          hold_d      = data_in;
          hold_full_d = 1'b1;
        end
      end else if (!hold_full_q) begin
        hold_d      = data_in;
        hold_full_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end

    // Outputs are registered, so they are decoded from the next state.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase
    busy_d    = (state_d != S_IDLE) || hold_full_d;
    tx_done_d = (state_q == S_STOP) && (count == CNT_W'(CLKS_PER_BIT - 2));
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    hold_q  <= hold_d;
`ifdef UART_TX_PARITY_EN
    parity_q <= parity_d;
`endif
    if (rst) begin
      state_q     <= S_IDLE;
      hold_full_q <= 1'b0;
      overrun_q   <= 1'b0;
      bit_idx_q   <= '0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      tx_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      overrun_q   <= overrun_d;
      bit_idx_q   <= bit_idx_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      tx_done_q   <= tx_done_d;
    end
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign tx_done = tx_done_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: frame-schedule reference model plus directed and random strobes.
module tb_uart_tx;

  localparam int C = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB  = 11;
  localparam bit PAR = 1'b1;
`else
  localparam int NB  = 10;
  localparam bit PAR = 1'b0;
`endif
  localparam int F = NB * C;

  logic       clk = 1'b0;
  logic       rst, data_valid;
  logic [7:0] data_in;
  logic       tx, busy, tx_done, overrun;

  uart_tx #(.CLKS_PER_BIT(C), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_valid (data_valid),
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  // Reference model: each accepted byte becomes a scheduled frame occupying F cycles.
  int         fs[$];
  int         fa[$];
  logic [7:0] fb[$];
  bit         ovr = 1'b0;
  bit         chk_en = 1'b0;
  logic       etx, ebusy, edone;
  int         n, st, k;

  function automatic logic exp_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (PAR && idx == 9) return ^b;
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      etx = 1'b1; ebusy = 1'b0; edone = 1'b0;
      for (int i = 0; i < fs.size(); i++) begin
        if (cyc >= fs[i] && cyc <= fs[i] + F - 1) begin
          k = (cyc - fs[i]) / C;
          etx = exp_bit(fb[i], k);
        end
        if (cyc == fs[i] + F - 1) edone = 1'b1;
        if (fa[i] < cyc && cyc <= fs[i] + F - 1) ebusy = 1'b1;
      end
      check("tx", tx, etx);
      check("busy", busy, ebusy);
      check("tx_done", tx_done, edone);
      check("overrun", overrun, ovr);
    end
    if (rst) begin
      fs.delete(); fa.delete(); fb.delete();
      ovr = 1'b0;
    end else if (data_valid) begin
      n = 0;
      for (int i = 0; i < fs.size(); i++) if (fs[i] > cyc + 1) n++;
      if (n == 0) begin
        st = cyc + 1;
        if (fs.size() > 0 && fs[fs.size()-1] + F > st) st = fs[fs.size()-1] + F;
        fs.push_back(st); fa.push_back(cyc); fb.push_back(data_in);
      end else begin
        ovr = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
    data_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic strobe(input logic [7:0] b);
    data_valid = 1'b1;
    data_in = b;
  endtask

  task automatic wait_cycles(input int cnt);
    repeat (cnt) step();
  endtask

  initial begin
    rst = 1'b1; data_valid = 1'b0; data_in = 8'h00;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0; chk_en = 1'b1;
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_overrun", overrun, 0);
    wait_cycles(5);

    // Single byte
    step(); strobe(8'hA5);
    step();
    check("s1_start_tx", tx, 0);
    check("s1_busy", busy, 1);
    repeat (F - 1) step();
    check("s1_tx_done", tx_done, 1);
    step();
    check("s1_idle_busy", busy, 0);
    check("s1_done_clear", tx_done, 0);
    wait_cycles(10);

    // Back-to-back
    step(); strobe(8'h55);
    step(); step(); strobe(8'h0F);
    repeat (F - 1) step();
    check("s2_second_start", tx, 0);
    check("s2_busy", busy, 1);
    wait_cycles(F + 10);
    check("s2_overrun", overrun, 0);

    // Overrun
    step(); strobe(8'h01);
    step(); step(); strobe(8'h02);
    step(); step(); strobe(8'h03);
    step();
    check("s3_overrun", overrun, 1);
    wait_cycles(2 * F + 10);
    step(); rst = 1'b1;
    step();
    check("s3_overrun_cleared", overrun, 0);
    wait_cycles(5);

    // Strobe coinciding with stop end, hold full
    step(); strobe(8'h11);
    step(); step(); strobe(8'h22);
    repeat (F - 2) step();
    check("s4_tx_done", tx_done, 1);
    strobe(8'h77);
    wait_cycles(2 * F + 10);
    check("s4_overrun", overrun, 0);

    // Strobe coinciding with stop end, hold empty
    step(); strobe(8'h3C);
    repeat (F) step();
    strobe(8'hC3);
    wait_cycles(F + 10);

    // Reset mid-frame
    step(); strobe(8'h5A);
    repeat (15) step();
    rst = 1'b1;
    step();
    check("s5_tx", tx, 1);
    check("s5_busy", busy, 0);
    check("s5_overrun", overrun, 0);
    wait_cycles(5);
    step(); strobe(8'h96);
    wait_cycles(F + 10);

    // Random traffic: dense then sparse
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 1500; i++) begin
        step();
        if ($urandom_range(0, 99) < (ph == 0 ? 8 : 2)) strobe(8'($urandom));
        else if ($urandom_range(0, 399) == 0) rst = 1'b1;
      end
    end
    wait_cycles(3 * F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
